mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit for the pipelined MIPS core, located in the E stage beside the ALU.
- Owns the architectural HI/LO registers.
- Produces the values that mfhi/mflo forward toward the general register file write port.
- Models fixed multi-cycle latency through a busy flag, which the hazard unit uses to stall md-class instructions in D.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15
DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
md_op  input  4  operation in E this cycle: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MSUB; all other codes are NONE
rs_val  input  32  operand A (forwarded rs value)
rt_val  input  32  operand B (forwarded rt value)
busy  output  1  high while an operation is in flight
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (synchronous, on clk edge with reset=1): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset wins over any md_op in the same cycle and aborts any in-flight operation; that operation's result is never committed.
- States: IDLE (busy=0) and RUN (busy=1). A 4-bit down-counter counts the RUN cycles.
- IDLE, md_op in {MULT, MULTU, DIV, DIVU, MADD, MSUB} at edge t:
  - Operands are captured and the 64-bit result is computed into a pending {phi, plo} register at that edge.
  - busy goes high from cycle t+1.
  - Counter is loaded with N-1, where N = MULT_CYCLES or DIV_CYCLES.
- RUN: the counter decrements each edge. At the edge where counter==0, hi/lo take phi/plo and busy drops. Busy is therefore high for exactly N cycles; new hi/lo are first visible in the cycle busy is low again.
- hi/lo hold their old values for the whole of RUN. Changes to rs_val/rt_val after the start edge have no effect.
- md_op issued while busy=1 (any code, including MTHI/MTLO) is ignored. The hazard unit guarantees this does not occur; the ignore rule is the defined fallback.
- MTHI/MTLO in IDLE: hi (or lo) takes rs_val at that edge, with zero latency; busy stays 0.
- MULT: signed 32x32 -> 64 bits; hi = upper 32, lo = lower 32.
- MULTU: same as MULT with unsigned operands.
- DIV: signed. lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val==0): busy still runs for DIV_CYCLES; at completion hi/lo are left unchanged.
- All arithmetic wraps modulo 2^64 in {hi, lo}; no exceptions are raised.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MADD: {hi, lo} <= {hi, lo} + signed(rs_val*rt_val), with MULT_CYCLES latency.
  - MSUB: same, but subtracting.
  - The accumulate base is the {hi, lo} value at the start edge.
- Undefined: codes 7 and 8 decode as NONE (no state change, busy stays 0), and no accumulate adder is synthesised.

Test Plan:
- Reset mid-run: issue DIV, assert reset in the 4th busy cycle -> the next cycle shows busy=0, hi=0, lo=0; the following 10 cycles show no commit.
- MULT rs=0xFFFFFFFE (-2), rt=3 at edge t -> busy high for cycles t+1..t+5; hi/lo hold their old values; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy for exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- Preload MTHI 0x11, MTLO 0x22 (zero latency, busy stays 0); then DIV with rt=0 -> busy runs 10 cycles, hi=0x11, lo=0x22 afterwards.
- Start MULT, then during busy present MTLO 0xAB and DIVU, and change rs/rt -> both ops are ignored; the final result is the original MULT; busy length is 5.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0 after 5 cycles. Undefined: the same md_op=7 -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage operation/operand bundle and HI/LO result bundle
// for the multiply/divide unit. The master side (pipeline) drives the
// operation and operands. The slave side (mdu_hilo) drives busy, hi and lo.
interface mdu_hilo_if;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output md_op, rs_val, rt_val, input  busy, hi, lo);
   modport slave  (input  md_op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the architectural HI/LO registers.
// The 64-bit result is computed at the start edge and parked in {phi, plo}.
// It is committed after a fixed latency that is modelled by a 4-bit
// down-counter, while busy is high.
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB, which accumulate
// into {hi, lo}. When it is undefined, codes 7 and 8 decode as NONE.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,   // 1..15
   parameter int DIV_CYCLES  = 10   // 1..15
) (
   input  logic        clk,
   input  logic        reset,
   mdu_hilo_if.slave   md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [3:0]    cnt;
   logic [31:0]   hi_q, lo_q;
   logic [31:0]   phi, plo;
   logic          pcommit;

   logic          is_mul, is_div, start;
   logic [63:0]   res;
   logic          res_ok;
   logic [3:0]    lat;

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic        [31:0] dvs;
   logic signed [31:0] sq, sr;
   logic        [31:0] uq, ur;

   // Decode the E-stage op. Ops arriving while RUN are dropped here.
   always_comb begin
      is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mul = is_mul || (md.md_op == OP_MADD) || (md.md_op == OP_MSUB);
`endif
      is_div = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
      start  = (state == IDLE) && (is_mul || is_div);
      lat    = is_div ? DIV_LAT : MULT_LAT;
   end

   // Arithmetic for the start edge. A zero divisor is replaced by 1 only so
   // that the divider never sees zero; that result is never committed.
   always_comb begin
      sprod = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
              $signed({{32{md.rt_val[31]}}, md.rt_val});
      uprod = {32'd0, md.rs_val} * {32'd0, md.rt_val};
      dvs   = (md.rt_val == 32'd0) ? 32'd1 : md.rt_val;
      sq    = $signed(md.rs_val) / $signed(dvs);
      sr    = $signed(md.rs_val) % $signed(dvs);
      // The most negative value divided by -1 wraps to itself with a zero
      // remainder, whatever the simulator does with the overflow.
      if (md.rs_val == 32'h8000_0000 && md.rt_val == 32'hFFFF_FFFF) begin
         sq = $signed(32'h8000_0000);
         sr = '0;
      end
      uq    = md.rs_val / dvs;
      ur    = md.rs_val % dvs;
      res   = '0;
      case (md.md_op)
         OP_MULT:  res = $unsigned(sprod);
         OP_MULTU: res = uprod;
         OP_DIV:   res = {$unsigned(sr), $unsigned(sq)};
         OP_DIVU:  res = {ur, uq};
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi_q, lo_q} + $unsigned(sprod);
         OP_MSUB:  res = {hi_q, lo_q} - $unsigned(sprod);
`endif
         default:  res = '0;
      endcase
      res_ok = !(is_div && (md.rt_val == 32'd0));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state: IDLE -> RUN on a start, RUN -> IDLE when the counter expires.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)      state_nx = RUN;
         RUN:     if (cnt == 4'd0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Pending result, the latency counter, the HI/LO commit and MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q    <= '0;
         lo_q    <= '0;
         phi     <= '0;
         plo     <= '0;
         pcommit <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         phi     <= res[63:32];
         plo     <= res[31:0];
         pcommit <= res_ok;
         cnt     <= lat;
      end else if (state == RUN) begin
         if (cnt == 4'd0) begin
            if (pcommit) begin
               hi_q <= phi;
               lo_q <= plo;
            end
            pcommit <= 1'b0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end else begin
         if (md.md_op == OP_MTHI) hi_q <= md.rs_val;
         if (md.md_op == OP_MTLO) lo_q <= md.rs_val;
      end
   end

   assign md.busy = (state == RUN);
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed test of mdu_hilo with a scoreboard. Each long op
// pushes its expected {hi, lo, busy length}. The monitor pops one entry on
// every busy falling edge that was not caused by reset.
module tb_mdu_hilo;
   logic clk = 1'b0;
   logic reset = 1'b1;
   mdu_hilo_if md ();

   mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: measure each busy run and check the commit when busy drops.
   int   run_len   = 0;
   logic prev_busy = 1'b0;
   logic prev_rst  = 1'b1;
   always @(negedge clk) begin
      if (md.busy === 1'b1) begin
         run_len++;
      end else begin
         if (prev_busy && !prev_rst) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_commit: got busy run %0d expected none", run_len);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_hi"}, md.hi, e.hi);
               chk({e.name, "_lo"}, md.lo, e.lo);
               chk({e.name, "_len"}, 32'(run_len), 32'(e.len));
            end
         end
         run_len = 0;
      end
      prev_busy = md.busy;
      prev_rst  = reset;
   end

   // Drive one op for one edge. This is called and returns at posedge+1.
   task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      md.md_op  = op;
      md.rs_val = a;
      md.rt_val = b;
      @(posedge clk); #1;
      md.md_op  = 4'd0;
   endtask

   task automatic push(string name, logic [31:0] h, logic [31:0] l, int len);
      exp_t e;
      e.name = name; e.hi = h; e.lo = l; e.len = len;
      sb.push_back(e);
   endtask

   task automatic wait_idle(string name);
      int k;
      k = 0;
      while (md.busy !== 1'b0 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 40) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, k);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      md.md_op = 4'd0; md.rs_val = '0; md.rt_val = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 32'(md.busy), 32'd0);
      chk("rst_hi", md.hi, 32'd0);
      chk("rst_lo", md.lo, 32'd0);

      // Reset in the 4th busy cycle of a DIV aborts it.
      issue(4'd5, 32'h5, 32'h0);
      issue(4'd6, 32'h6, 32'h0);
      issue(4'd3, 32'd100, 32'd7);
      repeat (3) begin @(posedge clk); #1; end
      chk("abort_busy_pre", 32'(md.busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", 32'(md.busy), 32'd0);
      chk("abort_hi", md.hi, 32'd0);
      chk("abort_lo", md.lo, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("abort_nocommit_busy", 32'(md.busy), 32'd0);
         chk("abort_nocommit_lo", md.lo, 32'd0);
      end

      // MULT: the old hi/lo hold throughout RUN.
      issue(4'd5, 32'h1234, 32'h0);
      issue(4'd6, 32'h5678, 32'h0);
      push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("mult_busy", 32'(md.busy), 32'd1);
         chk("mult_hold_hi", md.hi, 32'h1234);
         chk("mult_hold_lo", md.lo, 32'h5678);
         @(posedge clk); #1;
      end
      chk("mult_done_busy", 32'(md.busy), 32'd0);
      @(posedge clk); #1;

      push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
      issue(4'd2, 32'hFFFF_FFFE, 32'd3);
      wait_idle("multu");

      push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div");

      push("divu", 32'd1, 32'd3, 10);
      issue(4'd4, 32'd7, 32'd2);
      wait_idle("divu");

      push("div_ovf", 32'd0, 32'h8000_0000, 10);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf");

      // MTHI/MTLO take effect at once. Divide by zero leaves hi/lo alone.
      issue(4'd5, 32'h11, 32'h0);
      chk("mthi_busy", 32'(md.busy), 32'd0);
      chk("mthi_hi", md.hi, 32'h11);
      issue(4'd6, 32'h22, 32'h0);
      chk("mtlo_lo", md.lo, 32'h22);
      push("div0", 32'h11, 32'h22, 10);
      issue(4'd3, 32'd55, 32'd0);
      wait_idle("div0");

      // Ops issued during busy are ignored, and operand changes have no effect.
      push("ignore", 32'd0, 32'd30, 5);
      issue(4'd1, 32'd5, 32'd6);
      issue(4'd6, 32'hAB, 32'd9);
      issue(4'd4, 32'd100, 32'd3);
      md.rs_val = 32'hDEAD; md.rt_val = 32'hBEEF;
      wait_idle("ignore");

      // Unused codes are NONE.
      issue(4'd9, 32'h77, 32'h1);
      issue(4'd15, 32'h77, 32'h1);
      chk("none_busy", 32'(md.busy), 32'd0);
      chk("none_hi", md.hi, 32'd0);
      chk("none_lo", md.lo, 32'd30);

      issue(4'd5, 32'h0, 32'h0);
      issue(4'd6, 32'hFFFF_FFFF, 32'h0);
`ifdef MDU_MADD_EN
      push("madd", 32'd1, 32'd0, 5);
      issue(4'd7, 32'd1, 32'd1);
      wait_idle("madd");
      push("msub", 32'd0, 32'hFFFF_FFFA, 5);
      issue(4'd8, 32'd2, 32'd3);
      wait_idle("msub");
`else
      issue(4'd7, 32'd1, 32'd1);
      chk("madd_off_busy", 32'(md.busy), 32'd0);
      issue(4'd8, 32'd2, 32'd3);
      chk("msub_off_busy", 32'(md.busy), 32'd0);
      repeat (6) begin @(posedge clk); #1; end
      chk("madd_off_hi", md.hi, 32'd0);
      chk("madd_off_lo", md.lo, 32'hFFFF_FFFF);
`endif

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
